ahb_slave_if: RTL and testbench

AHB-side front end of the AHB-to-APB bridge, directly downstream of the AHB master. It samples the master's address/control and write data, and pipelines them for the APB controller. It decodes the address into one-hot peripheral selects and asserts valid for qualifying transfers. It owns the AHB response, including a two-cycle ERROR response for unmapped addresses.

---
 rtl/ahb_slave_if.sv | 112 +++++++++++
 tb/tb_ahb_slave_if.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge: address decode, transfer qualification,
// address/data pipelining and the AHB OKAY/ERROR response.
module ahb_slave_if #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned REGION_LOG2 = 26,
    parameter int unsigned NUM_SEL     = 3
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HWRITE,
    input  logic               HREADYin,
    input  logic [1:0]         HTRANS,
    input  logic [31:0]        HADDR,
    input  logic [31:0]        HWDATA,
    input  logic [31:0]        PRDATA,
    input  logic               apb_ready,
    output logic               valid,
    output logic [NUM_SEL-1:0] tempselx,
    output logic [31:0]        haddr_1,
    output logic [31:0]        haddr_2,
    output logic [31:0]        hwdata_1,
    output logic [31:0]        hwdata_2,
    output logic               hwrite_reg,
    output logic               hwrite_reg_1,
    output logic               HREADYout,
    output logic [1:0]         HRESP,
    output logic [31:0]        HRDATA
);

    typedef enum logic [1:0] {StOkay, StErr1, StErr2} state_e;

    state_e      state_q, state_d;
    logic [31:0] offset;
    logic [31:0] region;
    logic        mapped;
    logic        active;

    assign offset = HADDR - BASE_ADDR;
    assign region = offset >> REGION_LOG2;
    assign mapped = (HADDR >= BASE_ADDR) && (region < NUM_SEL);
    assign active = HREADYin && ((HTRANS == 2'b10) || (HTRANS == 2'b11));
    assign HRDATA = PRDATA;

    always_comb begin
        tempselx = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (HRESETn && mapped && (region == 32'(i))) begin
                tempselx[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid     = 1'b0;
        HREADYout = 1'b1;
        HRESP     = 2'b00;
        unique case (state_q)
            StOkay: begin
                HREADYout = apb_ready;
                valid     = active && mapped;
                if (active && !mapped) begin
                    state_d = StErr1;
                end
            end
            StErr1: begin
                HREADYout = 1'b0;
                HRESP     = 2'b01;
                state_d   = StErr2;
            end
            StErr2: begin
                // Transfer issued alongside the second error cycle is cancelled by the master.
                HRESP   = 2'b01;
                state_d = StOkay;
            end
            default: state_d = StOkay;
        endcase
        // Outputs read as idle while reset is held, independent of the clock.
        if (!HRESETn) begin
            valid     = 1'b0;
            HREADYout = 1'b1;
            HRESP     = 2'b00;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StOkay;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_1      <= '0;
            haddr_2      <= '0;
            hwdata_1     <= '0;
            hwdata_2     <= '0;
            hwrite_reg   <= 1'b0;
            hwrite_reg_1 <= 1'b0;
        end else if (HREADYin) begin
            haddr_1      <= HADDR;
            haddr_2      <= haddr_1;
            hwdata_1     <= HWDATA;
            hwdata_2     <= hwdata_1;
            hwrite_reg   <= HWRITE;
            hwrite_reg_1 <= hwrite_reg;
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ahb_slave_if;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HWRITE;
    logic        HREADYin;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] PRDATA;
    logic        apb_ready;
    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] haddr_1, haddr_2, hwdata_1, hwdata_2;
    logic        hwrite_reg, hwrite_reg_1;
    logic        HREADYout;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    int checks = 0;
    int errors = 0;

    ahb_slave_if dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HWRITE      (HWRITE),
        .HREADYin    (HREADYin),
        .HTRANS      (HTRANS),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .PRDATA      (PRDATA),
        .apb_ready   (apb_ready),
        .valid       (valid),
        .tempselx    (tempselx),
        .haddr_1     (haddr_1),
        .haddr_2     (haddr_2),
        .hwdata_1    (hwdata_1),
        .hwdata_2    (hwdata_2),
        .hwrite_reg  (hwrite_reg),
        .hwrite_reg_1(hwrite_reg_1),
        .HREADYout   (HREADYout),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          err_left;        // remaining ERROR-response cycles (2, 1, 0)
    logic [31:0] m_addr[$];       // most recently accepted beat first
    logic [31:0] m_data[$];
    logic        m_wr[$];

    function automatic int region_of(input logic [31:0] a);
        longint base = 64'h8000_0000;
        longint size = 64'd1 << 26;
        longint aa   = {32'd0, a};
        if (aa >= base && aa < base + 3 * size) return int'((aa - base) / size);
        return -1;
    endfunction

    function automatic bit is_active();
        return HREADYin && (HTRANS == 2'd2 || HTRANS == 2'd3);
    endfunction

    task automatic model_clear();
        err_left = 0;
        m_addr = '{32'd0, 32'd0};
        m_data = '{32'd0, 32'd0};
        m_wr   = '{1'b0, 1'b0};
    endtask

    initial model_clear();

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            model_clear();
        end else begin
            if (err_left > 0) err_left = err_left - 1;
            else if (is_active() && region_of(HADDR) < 0) err_left = 2;
            if (HREADYin) begin
                m_addr.push_front(HADDR);  m_addr.pop_back();
                m_data.push_front(HWDATA); m_data.pop_back();
                m_wr.push_front(HWRITE);   m_wr.pop_back();
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge HCLK) begin
        int          r;
        logic [2:0]  e_sel;
        logic        e_valid, e_ready;
        logic [1:0]  e_resp;
        r = region_of(HADDR);
        e_sel = (HRESETn && r >= 0) ? 3'(1 << r) : 3'b000;
        e_valid = HRESETn && is_active() && r >= 0 && err_left == 0;
        e_ready = !HRESETn ? 1'b1 : (err_left == 2) ? 1'b0 : (err_left == 1) ? 1'b1 : apb_ready;
        e_resp = (HRESETn && err_left != 0) ? 2'b01 : 2'b00;
        chk("m_valid", 32'(valid), 32'(e_valid));
        chk("m_tempselx", 32'(tempselx), 32'(e_sel));
        chk("m_hreadyout", 32'(HREADYout), 32'(e_ready));
        chk("m_hresp", 32'(HRESP), 32'(e_resp));
        chk("m_hrdata", HRDATA, PRDATA);
        chk("m_haddr_1", haddr_1, m_addr[0]);
        chk("m_haddr_2", haddr_2, m_addr[1]);
        chk("m_hwdata_1", hwdata_1, m_data[0]);
        chk("m_hwdata_2", hwdata_2, m_data[1]);
        chk("m_hwrite_reg", 32'(hwrite_reg), 32'(m_wr[0]));
        chk("m_hwrite_reg_1", 32'(hwrite_reg_1), 32'(m_wr[1]));
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w,
                         input logic [31:0] d, input logic rin, input logic ar);
        HADDR = a; HTRANS = t; HWRITE = w; HWDATA = d; HREADYin = rin; apb_ready = ar;
    endtask

    initial begin
        logic [31:0] addr_pool [6];
        addr_pool = '{32'h8000_0000, 32'h8400_1234, 32'h8BFF_FFFC,
                      32'h8C00_0000, 32'h7FFF_FFFC, 32'hFFFF_0000};
        HRESETn = 1'b0;
        PRDATA  = 32'hCAFE_F00D;
        drive(32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        #23;
        chk("rst_hreadyout", 32'(HREADYout), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_haddr_1", haddr_1, 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        HRESETn = 1'b1;
        next_cycle();

        // Single write
        drive(32'h8000_0001, 2'd2, 1'b1, 32'h0, 1'b1, 1'b1);
        @(negedge HCLK);
        chk("wr_valid", 32'(valid), 32'd1);
        chk("wr_sel", 32'(tempselx), 32'b001);
        next_cycle();
        drive(32'h0, 2'd0, 1'b0, 32'h0000_1122, 1'b1, 1'b1);
        @(negedge HCLK);
        chk("wr_haddr_1", haddr_1, 32'h8000_0001);
        chk("wr_hwrite_reg", 32'(hwrite_reg), 32'd1);
        next_cycle();
        drive(32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge HCLK);
        chk("wr_hwdata_1", hwdata_1, 32'h0000_1122);
        chk("wr_haddr_2", haddr_2, 32'h8000_0001);
        next_cycle();

        // Single read
        drive(32'h8400_0010, 2'd2, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge HCLK);
        chk("rd_valid", 32'(valid), 32'd1);
        chk("rd_sel", 32'(tempselx), 32'b010);
        chk("rd_hrdata", HRDATA, 32'hCAFE_F00D);
        next_cycle();
        drive(32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge HCLK);
        chk("rd_hwrite_reg", 32'(hwrite_reg), 32'd0);
        next_cycle();

        // Unmapped -> two-cycle ERROR
        drive(32'h9000_0000, 2'd2, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge HCLK);
        chk("um_valid", 32'(valid), 32'd0);
        chk("um_sel", 32'(tempselx), 32'd0);
        next_cycle();
        drive(32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge HCLK);
        chk("um1_ready", 32'(HREADYout), 32'd0);
        chk("um1_resp", 32'(HRESP), 32'd1);
        next_cycle();
        @(negedge HCLK);
        chk("um2_ready", 32'(HREADYout), 32'd1);
        chk("um2_resp", 32'(HRESP), 32'd1);
        next_cycle();
        @(negedge HCLK);
        chk("um3_resp", 32'(HRESP), 32'd0);
        next_cycle();

        // Qualifiers: IDLE and BUSY at a mapped address
        for (int t = 0; t < 2; t++) begin
            drive(32'h8800_0000, 2'(t), 1'b1, 32'h0, 1'b1, 1'b1);
            @(negedge HCLK);
            chk("q_valid", 32'(valid), 32'd0);
            chk("q_sel", 32'(tempselx), 32'b100);
            next_cycle();
        end
        // HREADYin low: pipeline holds
        drive(32'h8000_0040, 2'd2, 1'b1, 32'h0, 1'b1, 1'b1);
        next_cycle();
        drive(32'h8000_0080, 2'd2, 1'b1, 32'h0, 1'b1, 1'b1);
        next_cycle();
        drive(32'h8000_00C0, 2'd2, 1'b1, 32'h0, 1'b0, 1'b1);
        next_cycle();
        drive(32'h8000_0100, 2'd2, 1'b1, 32'h0, 1'b0, 1'b1);
        next_cycle();
        chk("hold_haddr_1", haddr_1, 32'h8000_0080);
        chk("hold_haddr_2", haddr_2, 32'h8000_0040);

        // Stall
        drive(32'h8000_0200, 2'd2, 1'b1, 32'h0, 1'b1, 1'b0);
        @(negedge HCLK);
        chk("st_ready", 32'(HREADYout), 32'd0);
        chk("st_resp", 32'(HRESP), 32'd0);
        apb_ready = 1'b1;
        #1;
        chk("st_release", 32'(HREADYout), 32'd1);
        next_cycle();

        // Reset in ERR1
        drive(32'h0000_1000, 2'd3, 1'b0, 32'h0, 1'b1, 1'b1);
        next_cycle();
        drive(32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        chk("e1_ready", 32'(HREADYout), 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("re_ready", 32'(HREADYout), 32'd1);
        chk("re_resp", 32'(HRESP), 32'd0);
        chk("re_haddr_1", haddr_1, 32'd0);
        chk("re_hwdata_2", hwdata_2, 32'd0);
        next_cycle();
        HRESETn = 1'b1;
        drive(32'h8000_0004, 2'd2, 1'b1, 32'h0, 1'b1, 1'b1);
        @(negedge HCLK);
        chk("re_wr_valid", 32'(valid), 32'd1);
        next_cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom() : addr_pool[$urandom_range(0, 5)];
            drive(a, 2'($urandom_range(0, 3)), 1'($urandom()), $urandom(),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
            PRDATA = $urandom();
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
